// File: rtl/pedometer_pkg.sv
// Shared types and constants for the pedometer step-counting datapath:
// weight-file roles, reset defaults and the detector state encoding.
package pedometer_pkg;

    localparam int NUM_W    = 8;
    localparam int W_GAIN_A = 0;
    localparam int W_GAIN_B = 1;
    localparam int W_THR_LO = 2;
    localparam int W_THR_HI = 3;
    localparam int W_HYST   = 4;

    typedef logic [NUM_W-1:0][7:0] weight_file_t;

    // Element 0 is the rightmost byte: gains 1/1, threshold 40, hysteresis 10.
    localparam weight_file_t W_RESET = {8'd0, 8'd0, 8'd0, 8'd10, 8'd0, 8'd40, 8'd1, 8'd1};

    typedef enum logic {
        BELOW = 1'b0,
        ABOVE = 1'b1
    } det_state_t;

endpackage

// File: rtl/pedometer_weight_rf.sv
// 8x8 detection-weight register file with two write ports; port 1 wins when
// both ports target the same entry. All entries are visible as outputs.
module pedometer_weight_rf
    import pedometer_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         we1,
    input  logic [2:0]   addr1,
    input  logic [7:0]   data1,
    input  logic         we2,
    input  logic [2:0]   addr2,
    input  logic [7:0]   data2,
    output weight_file_t w
);

    // Port 2 is written first so a same-address port 1 write overrides it.
    always_ff @(posedge clk) begin
        if (reset) begin
            w <= W_RESET;
        end else begin
            if (we2) w[addr2] <= data2;
            if (we1) w[addr1] <= data1;
        end
    end

endmodule

// File: rtl/pedometer.sv
// Step detector: weighted activity from two accelerometer axes, threshold
// crossing with hysteresis, and a saturating step counter.
module pedometer
    import pedometer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             countSteps,
    input  logic             updateWeight,
    input  logic             dualUpdateWeights,
    input  logic [7:0]       A,
    input  logic [7:0]       B,
    input  logic [2:0]       Addr1,
    input  logic [2:0]       Addr2,
    input  logic [7:0]       Data1,
    input  logic [7:0]       Data2,
    output logic [CNT_W-1:0] stepCount,
    output logic             stepPulse,
    output logic [16:0]      activity,
    output det_state_t       state
);

    weight_file_t w;
    logic         count_en;
    logic [15:0]  prod_a;
    logic [15:0]  prod_b;
    logic [16:0]  act;
    logic [15:0]  thr;
    logic [15:0]  thr_low;

    // Only the highest-priority request acts; lower ones are dropped.
    assign count_en = countSteps & ~dualUpdateWeights & ~updateWeight;

    pedometer_weight_rf u_weight_rf (
        .clk   (clk),
        .reset (reset),
        .we1   (dualUpdateWeights | updateWeight),
        .addr1 (Addr1),
        .data1 (Data1),
        .we2   (dualUpdateWeights),
        .addr2 (Addr2),
        .data2 (Data2),
        .w     (w)
    );

    assign prod_a  = 16'(w[W_GAIN_A]) * 16'(A);
    assign prod_b  = 16'(w[W_GAIN_B]) * 16'(B);
    assign act     = {1'b0, prod_a} + {1'b0, prod_b};
    assign thr     = {w[W_THR_HI], w[W_THR_LO]};
    assign thr_low = (thr > 16'(w[W_HYST])) ? thr - 16'(w[W_HYST]) : 16'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= BELOW;
            stepCount <= '0;
            stepPulse <= 1'b0;
            activity  <= '0;
        end else begin
            stepPulse <= 1'b0;
            if (count_en) begin
                activity <= act;
                case (state)
                    BELOW: begin
                        if (act > {1'b0, thr}) begin
                            state     <= ABOVE;
                            stepPulse <= 1'b1;
                            if (stepCount != '1) stepCount <= stepCount + 1'b1;
                        end
                    end
                    ABOVE: begin
                        if (act < {1'b0, thr_low}) state <= BELOW;
                    end
                    default: state <= BELOW;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pedometer.sv
// Directed and randomised checks of the pedometer against a behavioural
// reference model, compared through an expected-result queue each cycle.
module tb_pedometer;
    import pedometer_pkg::*;

    localparam int CNT_W = 16;
    localparam int EXP_W = CNT_W + 1 + 17 + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             countSteps, updateWeight, dualUpdateWeights;
    logic [7:0]       A, B, Data1, Data2;
    logic [2:0]       Addr1, Addr2;
    logic [CNT_W-1:0] stepCount;
    logic             stepPulse;
    logic [16:0]      activity;
    det_state_t       state;

    int vectors    = 0;
    int miscompares = 0;

    logic [EXP_W-1:0] exp_q[$];

    // Reference model state
    logic [7:0]       m_w [8];
    logic             m_state;
    logic [CNT_W-1:0] m_cnt;
    logic             m_pulse;
    logic [16:0]      m_act;

    pedometer #(.CNT_W(CNT_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .countSteps        (countSteps),
        .updateWeight      (updateWeight),
        .dualUpdateWeights (dualUpdateWeights),
        .A                 (A),
        .B                 (B),
        .Addr1             (Addr1),
        .Addr2             (Addr2),
        .Data1             (Data1),
        .Data2             (Data2),
        .stepCount         (stepCount),
        .stepPulse         (stepPulse),
        .activity          (activity),
        .state             (state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_w[0] = 8'd1;  m_w[1] = 8'd1;  m_w[2] = 8'd40; m_w[3] = 8'd0;
        m_w[4] = 8'd10; m_w[5] = 8'd0;  m_w[6] = 8'd0;  m_w[7] = 8'd0;
        m_state = 1'b0;
        m_cnt   = '0;
        m_pulse = 1'b0;
        m_act   = '0;
    endtask

    task automatic model_step();
        logic [16:0] a_now;
        logic [15:0] t, h, tl;
        a_now = 17'(m_w[0]) * 17'(A) + 17'(m_w[1]) * 17'(B);
        t  = {m_w[3], m_w[2]};
        h  = 16'(m_w[4]);
        tl = (h >= t) ? 16'd0 : t - h;
        m_pulse = 1'b0;
        if (reset) begin
            model_reset();
        end else if (dualUpdateWeights) begin
            m_w[Addr2] = Data2;
            m_w[Addr1] = Data1;
        end else if (updateWeight) begin
            m_w[Addr1] = Data1;
        end else if (countSteps) begin
            m_act = a_now;
            if (!m_state && a_now > 17'(t)) begin
                m_state = 1'b1;
                m_pulse = 1'b1;
                if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
            end else if (m_state && a_now < 17'(tl)) begin
                m_state = 1'b0;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic set_in(input logic rst, input logic cs, input logic uw, input logic duw,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] a1, input logic [7:0] d1,
                          input logic [2:0] a2, input logic [7:0] d2);
        reset = rst; countSteps = cs; updateWeight = uw; dualUpdateWeights = duw;
        A = a; B = b; Addr1 = a1; Data1 = d1; Addr2 = a2; Data2 = d2;
    endtask

    // One clock: model predicts, push expectation, then pop and compare after the edge.
    task automatic cycle(input string tag);
        logic [EXP_W-1:0] exp_v, obs_v;
        model_step();
        exp_q.push_back({m_cnt, m_pulse, m_act, m_state});
        @(posedge clk);
        #1;
        obs_v = {stepCount, stepPulse, activity, state};
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s scoreboard empty observed=%h", tag, obs_v);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs_v === exp_v) else begin
                miscompares++;
                $error("FAIL %s observed cnt=%0d pulse=%b act=%0d st=%b expected cnt=%0d pulse=%b act=%0d st=%b",
                       tag, obs_v[EXP_W-1 -: CNT_W], obs_v[18], obs_v[17:1], obs_v[0],
                       exp_v[EXP_W-1 -: CNT_W], exp_v[18], exp_v[17:1], exp_v[0]);
            end
        end
    endtask

    task automatic count(input string tag, input logic [7:0] a, input logic [7:0] b);
        set_in(0, 1, 0, 0, a, b, 3'd0, 8'd0, 3'd0, 8'd0);
        cycle(tag);
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        vectors++;
        assert (obs === exp_val) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_val);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        set_in(1, 0, 0, 0, 8'd0, 8'd0, 3'd0, 8'd0, 3'd0, 8'd0);
        cycle("reset");
        set_in(1, 0, 0, 0, 8'd0, 8'd0, 3'd0, 8'd0, 3'd0, 8'd0);
        cycle("reset2");
        check_val("reset_cnt", 32'(stepCount), 0);
        check_val("reset_act", 32'(activity), 0);

        // First step at act=60 > 40
        count("step1", 8'd30, 8'd30);
        check_val("step1_cnt", 32'(stepCount), 1);
        check_val("step1_pulse", 32'(stepPulse), 1);
        check_val("step1_act", 32'(activity), 60);

        count("drop20", 8'd10, 8'd10);
        check_val("drop_state", 32'(state), 32'(BELOW));
        count("step2", 8'd30, 8'd30);
        check_val("step2_cnt", 32'(stepCount), 2);

        for (int i = 0; i < 5; i++) count("hyst_hold", 8'd30, 8'd30);
        check_val("hyst_cnt", 32'(stepCount), 2);
        check_val("hyst_pulse", 32'(stepPulse), 0);

        set_in(0, 0, 0, 0, 8'd99, 8'd99, 3'd0, 8'd0, 3'd0, 8'd0);
        cycle("idle");

        // Weight write beats countSteps in the same cycle
        count("drop_b", 8'd10, 8'd10);
        set_in(0, 1, 1, 0, 8'd30, 8'd30, 3'd1, 8'd5, 3'd0, 8'd0);
        cycle("uw_drops_cs");
        check_val("uw_no_step", 32'(stepCount), 2);
        count("gain_b5", 8'd30, 8'd30);
        check_val("gain_b5_act", 32'(activity), 180);
        check_val("gain_b5_cnt", 32'(stepCount), 3);

        // Restore gain B, then T=100, H=0 via dual write
        count("drop_c", 8'd0, 8'd0);
        set_in(0, 0, 1, 0, 8'd0, 8'd0, 3'd1, 8'd1, 3'd0, 8'd0);
        cycle("restore_gb");
        set_in(0, 1, 0, 1, 8'd0, 8'd0, 3'd2, 8'd100, 3'd4, 8'd0);
        cycle("dual_thr");
        count("act_eq_t", 8'd50, 8'd50);
        check_val("act_eq_t_cnt", 32'(stepCount), 3);
        count("act_gt_t", 8'd51, 8'd51);
        check_val("act_gt_t_cnt", 32'(stepCount), 4);
        count("eq_tlow_h0", 8'd50, 8'd50);
        check_val("eq_tlow_state", 32'(state), 32'(ABOVE));
        count("below_tlow", 8'd49, 8'd50);
        check_val("below_tlow_state", 32'(state), 32'(BELOW));

        // H=10, Tlow=90: act=90 stays ABOVE, 88 drops
        set_in(0, 0, 1, 0, 8'd0, 8'd0, 3'd4, 8'd10, 3'd0, 8'd0);
        cycle("set_h10");
        count("up_again", 8'd60, 8'd60);
        count("act_90", 8'd45, 8'd45);
        count("act_88", 8'd44, 8'd44);

        // Same-address dual write: Data1 wins
        set_in(0, 0, 0, 1, 8'd0, 8'd0, 3'd0, 8'd5, 3'd0, 8'd6);
        cycle("dual_same_addr");
        count("gain_a5", 8'd10, 8'd0);
        check_val("gain_a5_act", 32'(activity), 50);

        // Reset mid-operation restores defaults
        set_in(1, 1, 0, 0, 8'd200, 8'd200, 3'd0, 8'd0, 3'd0, 8'd0);
        cycle("mid_reset");
        check_val("mid_reset_cnt", 32'(stepCount), 0);
        count("default_eq", 8'd20, 8'd20);
        check_val("default_eq_cnt", 32'(stepCount), 0);
        count("default_gt", 8'd21, 8'd20);
        check_val("default_gt_cnt", 32'(stepCount), 1);
        check_val("default_gt_act", 32'(activity), 41);

        // T=0, H=0: one step on nonzero act, then stuck ABOVE
        count("drop_d", 8'd0, 8'd0);
        set_in(0, 0, 0, 1, 8'd0, 8'd0, 3'd2, 8'd0, 3'd3, 8'd0);
        cycle("t_zero");
        set_in(0, 0, 1, 0, 8'd0, 8'd0, 3'd4, 8'd0, 3'd0, 8'd0);
        cycle("h_zero");
        count("zero_act", 8'd0, 8'd0);
        count("one_act", 8'd1, 8'd0);
        count("zero_stuck", 8'd0, 8'd0);
        count("zero_stuck2", 8'd3, 8'd3);
        check_val("t0_cnt", 32'(stepCount), 2);

        // Randomised mix against the model
        set_in(1, 0, 0, 0, 8'd0, 8'd0, 3'd0, 8'd0, 3'd0, 8'd0);
        cycle("rand_reset");
        for (int i = 0; i < 400; i++) begin
            int op;
            op = $urandom_range(0, 99);
            set_in(op == 0, op < 85, (op >= 80 && op < 92), (op >= 90 && op < 96),
                   8'($urandom_range(0, 60)), 8'($urandom_range(0, 60)),
                   3'($urandom_range(0, 7)), 8'($urandom_range(0, 80)),
                   3'($urandom_range(0, 7)), 8'($urandom_range(0, 20)));
            cycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
